systolic_seq_ctrl: RTL and testbench

- Sequencer for a DIM x DIM systolic array of tpumac cells.
- On start, it zeroes the accumulators, then runs the skewed compute phase: it generates per-row and per-column feed-valid masks and drives the array-wide MAC enable.
- It then drains results one row per cycle and pulses done.
- It sits between the host/command logic and the A/B feeder memories plus the MAC array.

---
 rtl/systolic_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// Purpose : sequences a DIM x DIM systolic MAC array through clear, skewed compute and row drain.
// Latency : done pulses 1 + k + 2*(DIM-1) + DIM cycles after the cycle following a sampled start.
// Backpres: none; start is ignored while busy or in DONE, abort returns to IDLE on the next cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, k_len        begin a matmul of reduction length k_len (clamped to KMAX), sampled in IDLE
//   abort               synchronous abort from any non-IDLE state
//   busy, done          activity flag (CLEAR/COMPUTE/DRAIN) and one-cycle completion pulse
//   clr, mac_en         accumulator zeroing strobe and array-wide MAC enable
//   step                compute step index, 0 outside COMPUTE
//   row_valid/col_valid per-row A / per-column B feed-valid masks (skewed wavefront)
//   drain_en, drain_row Cout chain shift enable and index of the row being drained
module systolic_seq_ctrl #(
    parameter int DIM    = 8,
    parameter int KMAX   = 64,
    parameter int STEP_W = $clog2(KMAX + 2 * DIM),
    parameter int K_W    = $clog2(KMAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [K_W-1:0]          k_len,
    output logic                    busy,
    output logic                    done,
    output logic                    clr,
    output logic                    mac_en,
    output logic [STEP_W-1:0]       step,
    output logic [DIM-1:0]          row_valid,
    output logic [DIM-1:0]          col_valid,
    output logic                    drain_en,
    output logic [$clog2(DIM)-1:0]  drain_row
);

    localparam int RW  = $clog2(DIM);
    // One extra bit so step+k and last-step arithmetic cannot wrap.
    localparam int SW1 = STEP_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [K_W-1:0]   k_q;
    logic [DIM-1:0]   mask_q;
    logic [SW1-1:0]   last_step;

    // Final compute step: the last row/column sees its last operand at
    // step (DIM-1) + (k-1); the opposite corner needs another DIM-1 steps.
    assign last_step = SW1'(k_q) + SW1'(2 * (DIM - 1)) - SW1'(1);

    // Row and column feeders share the same skew, so one mask serves both.
    assign row_valid = mask_q;
    assign col_valid = mask_q;

    // Lane i is fed while its skewed window [i, i+k) covers step s.
    function automatic logic [DIM-1:0] mask_at(input logic [STEP_W-1:0] s,
                                               input logic [K_W-1:0]    kk);
        logic [DIM-1:0] m;
        logic [SW1-1:0] sw;
        logic [SW1-1:0] lo;
        logic [SW1-1:0] hi;
        m  = '0;
        sw = {1'b0, s};
        for (int i = 0; i < DIM; i++) begin
            lo   = SW1'(i);
            hi   = lo + SW1'(kk);
            m[i] = (sw >= lo) && (sw < hi);
        end
        return m;
    endfunction

    // Outputs are registered: each branch loads the values for the state
    // being entered, so they line up with that state's first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k_q       <= '0;
            mask_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            clr       <= 1'b0;
            mac_en    <= 1'b0;
            step      <= '0;
            drain_en  <= 1'b0;
            drain_row <= '0;
        end else if (abort && state != S_IDLE) begin
            state     <= S_IDLE;
            mask_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            clr       <= 1'b0;
            mac_en    <= 1'b0;
            step      <= '0;
            drain_en  <= 1'b0;
            drain_row <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // abort together with start keeps us idle
                    if (start && !abort) begin
                        k_q   <= (k_len > K_W'(KMAX)) ? K_W'(KMAX) : k_len;
                        state <= S_CLEAR;
                        clr   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    clr <= 1'b0;
                    if (k_q != '0) begin
                        state  <= S_COMPUTE;
                        mac_en <= 1'b1;
                        step   <= '0;
                        mask_q <= mask_at('0, k_q);
                    end else begin
                        // Nothing to accumulate: drain the freshly cleared zeros.
                        state     <= S_DRAIN;
                        drain_en  <= 1'b1;
                        drain_row <= '0;
                    end
                end
                S_COMPUTE: begin
                    if ({1'b0, step} == last_step) begin
                        state     <= S_DRAIN;
                        mac_en    <= 1'b0;
                        step      <= '0;
                        mask_q    <= '0;
                        drain_en  <= 1'b1;
                        drain_row <= '0;
                    end else begin
                        step   <= step + STEP_W'(1);
                        mask_q <= mask_at(step + STEP_W'(1), k_q);
                    end
                end
                S_DRAIN: begin
                    if (drain_row == RW'(DIM - 1)) begin
                        state     <= S_DONE;
                        drain_en  <= 1'b0;
                        drain_row <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        drain_row <= drain_row + RW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
module tb_systolic_seq_ctrl;

    localparam int D  = 4;
    localparam int KM = 64;
    localparam int SW = $clog2(KM + 2 * D);
    localparam int KW = $clog2(KM + 1);
    localparam int RW = $clog2(D);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          busy, done, clr, mac_en, drain_en;
    logic [SW-1:0] step;
    logic [D-1:0]  row_valid, col_valid;
    logic [RW-1:0] drain_row;

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.DIM(D), .KMAX(KM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .k_len(k_len),
        .busy(busy), .done(done), .clr(clr), .mac_en(mac_en), .step(step),
        .row_valid(row_valid), .col_valid(col_valid),
        .drain_en(drain_en), .drain_row(drain_row)
    );

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          clr;
        logic          mac_en;
        logic [SW-1:0] step;
        logic [D-1:0]  rv;
        logic [D-1:0]  cv;
        logic          drain_en;
        logic [RW-1:0] drain_row;
    } obs_t;

    obs_t obs;
    assign obs = {busy, done, clr, mac_en, step, row_valid, col_valid, drain_en, drain_row};

    obs_t expq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle outputs of one full matmul, derived from the cycle-level behaviour.
    task automatic push_seq(input int k);
        obs_t o;
        int   kc;
        kc = (k > KM) ? KM : k;
        o = '0; o.busy = 1'b1; o.clr = 1'b1;
        expq.push_back(o);
        if (kc > 0) begin
            for (int s = 0; s < kc + 2 * (D - 1); s++) begin
                o = '0; o.busy = 1'b1; o.mac_en = 1'b1; o.step = SW'(s);
                for (int r = 0; r < D; r++) begin
                    o.rv[r] = (s >= r) && (s < r + kc);
                    o.cv[r] = (s >= r) && (s < r + kc);
                end
                expq.push_back(o);
            end
        end
        for (int r = 0; r < D; r++) begin
            o = '0; o.busy = 1'b1; o.drain_en = 1'b1; o.drain_row = RW'(r);
            expq.push_back(o);
        end
        o = '0; o.done = 1'b1;
        expq.push_back(o);
        expq.push_back('0);
    endtask

    // Launch a matmul and compare every cycle against the scoreboard.
    // abort_at / start_at: queue index at which abort / a stray start is driven (-1 = never).
    task automatic run_seq(input string name, input int k, input int abort_at,
                           input int start_at, input int later_k);
        obs_t e;
        int   idx;
        expq.delete();
        push_seq(k);
        if (abort_at >= 0) begin
            while (expq.size() > abort_at + 1) void'(expq.pop_back());
            expq.push_back('0);
            expq.push_back('0);
        end
        k_len = KW'(k);
        start = 1'b1;
        tick();
        start = 1'b0;
        k_len = KW'(later_k);
        idx = 0;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, idx, obs, e);
            end
            start = (idx == start_at);
            abort = (idx == abort_at);
            tick();
            idx++;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b1;
        k_len = KW'(3);
        repeat (3) tick();
        checks++;
        if (obs !== obs_t'('0) || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected 0", obs);
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== obs_t'('0)) begin
            errors++;
            $display("FAIL reset_release: got %h expected 0", obs);
        end
    endtask

    task automatic test_abort_start_idle();
        k_len = KW'(3);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (2) begin
            checks++;
            if (obs !== obs_t'('0)) begin
                errors++;
                $display("FAIL abort_start_idle: got %h expected 0", obs);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        int n;
        k_len = KW'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (drain_en !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (drain_en !== 1'b1) begin
            errors++;
            $display("FAIL async_wait_drain: drain_en=%b expected 1 within 100 cycles", drain_en);
        end
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== obs_t'('0)) begin
            errors++;
            $display("FAIL async_reset_immediate: got %h expected 0", obs);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL async_after_release cycle %0d: done=%b busy=%b expected 0 0", i, done, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        run_seq("basic_k3", 3, -1, -1, 3);
        run_seq("k_zero", 0, -1, -1, 0);
        run_seq("k_clamp", KM + 5, -1, -1, 0);
        run_seq("start_mid_compute", 3, -1, 4, 7);
        // done index for k=2 is 1 + 2 + 2*(D-1) + D = 13
        run_seq("start_in_done", 2, -1, 13, 5);
        run_seq("abort_step2", 3, 3, -1, 3);
        run_seq("after_abort", 3, -1, -1, 3);
        test_abort_start_idle();
        run_seq("k_one", 1, -1, -1, 1);
        test_async_reset();
        run_seq("after_async_reset", 4, -1, -1, 4);
        run_seq("back_to_back", 4, -1, -1, 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
